lu_acc: RTL
===========

Name: lu_acc

Overview:
- Parametrised W-bit logic unit with 8 selectable bitwise operations.
- Has a registered output stage with a valid/ready handshake, and an accumulator register that can replace operand A, so ops can be chained.
- Successor to the 1-bit AND/NAND/OR/NOR selectable unit. Serves as the logic slice of the upcoming datapath exercises.

Parameters:
- W, 8, operand/result width in bits (legal range 1..64).
- ACC_RST, 0, accumulator value loaded on reset and on acc_clr (W bits).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/op bundle present.
- in_ready  output  1  block can accept a bundle this cycle.
- op  input  3  operation select (encodings below).
- use_acc  input  1  1: operand A = accumulator; 0: operand A = a.
- a  input  W  operand A.
- b  input  W  operand B.
- acc_clr  input  1  synchronous accumulator clear.
- out_valid  output  1  out_data holds an undelivered result.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  W  registered result.
- out_zero  output  1  registered flag: out_data == 0.
- acc  output  W  current accumulator value.

Behaviour:
- Reset (reset=1 at clk edge) sets:
  - out_valid=0, out_data=0, out_zero=0, acc=ACC_RST.
  - reset overrides every other input that cycle.
- Opcodes, with A = use_acc ? acc : a:
  - 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR.
  - 110 NOT A, 111 PASS B.
- Result is a pure W-bit bitwise function; no carries, no width growth.
- in_ready = !out_valid || out_ready. It is combinational and does not depend on in_valid.
- Accept = in_valid && in_ready. On accept, at the next edge:
  - out_data <= result, out_zero <= (result==0), out_valid <= 1.
  - acc <= result.
- Latency: 1 cycle from accept to out_valid=1.
- Output drain: if out_valid && out_ready && !accept, then out_valid <= 0. out_data/out_zero hold their last value.
- Simultaneous drain + accept (full throughput): out_valid stays 1 and out_data takes the new result. Sustained rate is 1 result per cycle.
- Stall: if out_valid && !out_ready, then in_ready=0, out_data is held stable, and acc is unchanged.
- acc_clr=1 at an edge sets acc <= ACC_RST, with priority over the accept update of acc.
  - An op accepted in the same cycle still uses the old acc as A.
  - That op's result still goes to out_data.
- use_acc with no prior accept uses ACC_RST as A.
- in_valid=0 leaves acc unchanged. op/a/b are ignored when not accepted.
- Reset mid-stall discards the pending result; out_valid=0 on the next cycle.

Optional Feature:
- Macro LU_ACC_PARITY_EN adds output out_par (1 bit, registered) = XOR-reduce of the accepted result.
  - Updated on accept, 0 on reset, held otherwise.
- Without the macro: the port and its flop do not exist, and all other behaviour is identical.

Decomposition:
- Package lu_pkg holds:
  - opcode localparams OP_AND..OP_PASSB (3-bit);
  - the op-width constant OPW=3.
- Sub-module lu_core: purely combinational, parameter W; inputs op/a/b, output result. All 8 ops live here.
- lu_acc contains only:
  - operand-A select;
  - handshake logic;
  - output, flag and accumulator registers.

Test Plan:
- Reset, then op=000, a=8'hF0, b=8'h3C, use_acc=0, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=8'h30, out_zero=0, acc=8'h30.
- Exhaustive ops with a=8'hAA, b=8'h0F:
  - results 0A, F5, AF, 50, A5, 5A, 55, 0F in order;
  - back-to-back accepts, one result per cycle.
- Chain: op=PASSB b=8'h01, then use_acc=1 op=XOR b=8'h03, then use_acc=1 op=OR b=8'h10 -> results 01, 02, 12; acc=8'h12.
- Backpressure:
  - hold out_ready=0 for 3 cycles with a result pending -> in_ready=0, out_data stable, acc unchanged;
  - raise out_ready with in_valid=1 -> drain and new accept in the same cycle.
- acc_clr coincident with accept (use_acc=1, acc=8'h12, op=AND, b=8'hFF) -> out_data=8'h12, acc=ACC_RST=0.
- Zero flag and reset: op=AND a=8'h0F b=8'hF0 -> out_zero=1. Then assert reset while stalled -> out_valid=0, out_zero=0, acc=0. With LU_ACC_PARITY_EN also check out_par on a=8'h07 PASS A... via op=NOT A on a=8'hF8 -> result 07 -> out_par=1.

Source files
------------

// File: rtl/lu_pkg.sv
// Shared opcode encodings for the lu_acc logic slice.
package lu_pkg;

    localparam int unsigned OPW = 3;

    localparam logic [OPW-1:0] OP_AND   = 3'b000;
    localparam logic [OPW-1:0] OP_NAND  = 3'b001;
    localparam logic [OPW-1:0] OP_OR    = 3'b010;
    localparam logic [OPW-1:0] OP_NOR   = 3'b011;
    localparam logic [OPW-1:0] OP_XOR   = 3'b100;
    localparam logic [OPW-1:0] OP_XNOR  = 3'b101;
    localparam logic [OPW-1:0] OP_NOTA  = 3'b110;
    localparam logic [OPW-1:0] OP_PASSB = 3'b111;

endpackage

// File: rtl/lu_core.sv
// Combinational W-bit bitwise function unit: all eight logic ops, no carries.
module lu_core
    import lu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [OPW-1:0] op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   result
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:   result = a & b;
            OP_NAND:  result = ~(a & b);
            OP_OR:    result = a | b;
            OP_NOR:   result = ~(a | b);
            OP_XOR:   result = a ^ b;
            OP_XNOR:  result = ~(a ^ b);
            OP_NOTA:  result = ~a;
            OP_PASSB: result = b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/lu_acc.sv
// Logic unit with registered valid/ready output stage and chaining accumulator.
// Optional registered parity output out_par when LU_ACC_PARITY_EN is defined.
module lu_acc
    import lu_pkg::*;
#(
    parameter int unsigned     W       = 8,
    parameter logic [W-1:0]    ACC_RST = '0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] op,
    input  logic           use_acc,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           acc_clr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_zero,
`ifdef LU_ACC_PARITY_EN
    output logic           out_par,
`endif
    output logic [W-1:0]   acc
);

    logic [W-1:0] opa;
    logic [W-1:0] result;
    logic         accept;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic         out_zero_q,  out_zero_d;
    logic [W-1:0] acc_q,       acc_d;
`ifdef LU_ACC_PARITY_EN
    logic         out_par_q,   out_par_d;
`endif

    assign opa      = use_acc ? acc_q : a;
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    lu_core #(.W(W)) u_core (
        .op     (op),
        .a      (opa),
        .b      (b),
        .result (result)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_zero_d  = out_zero_q;
        acc_d       = acc_q;
`ifdef LU_ACC_PARITY_EN
        out_par_d   = out_par_q;
`endif
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = result;
            out_zero_d  = (result == '0);
`ifdef LU_ACC_PARITY_EN
            out_par_d   = ^result;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // Clear wins over the accept write; the accepted op already saw the old acc.
        if (acc_clr) begin
            acc_d = ACC_RST;
        end else if (accept) begin
            acc_d = result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b0;
            acc_q       <= ACC_RST;
`ifdef LU_ACC_PARITY_EN
            out_par_q   <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_zero_q  <= out_zero_d;
            acc_q       <= acc_d;
`ifdef LU_ACC_PARITY_EN
            out_par_q   <= out_par_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;
    assign acc       = acc_q;
`ifdef LU_ACC_PARITY_EN
    assign out_par   = out_par_q;
`endif

endmodule
